// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_pkg
//  Description : Shared types and op-decoding helpers for the iterative
//                RV32M/RV64M multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_muldiv_pkg;

    // Operation encoding equals the instruction funct3 field
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

    // rs1 is two's complement for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_rs1(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    // rs2 is two's complement for MULH, DIV and REM (MULHSU treats it unsigned)
    function automatic logic is_signed_rs2(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage : alu_muldiv_pkg
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative one-bit-per-cycle multiply/divide unit for the
//                M extension, with valid/ready handshakes and flush abort.
//                Magnitudes are processed unsigned; signs are applied in FIXUP.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_state_e         w_next_state;
    md_op_e            r_op;
    logic              r_neg_res;     // product/quotient sign flip
    logic              r_neg_rem;     // remainder follows dividend sign
    logic [XLEN-1:0]   r_abs_a;       // |rs1|: multiplicand
    logic [XLEN-1:0]   r_abs_b;       // |rs2|: divisor
    logic [2*XLEN-1:0] r_prod;        // high: partial sum, low: multiplier bits
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;         // dividend bits shift out, quotient bits in
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    md_op_e            w_op;
    logic              w_accept;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_result;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_sub;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_op     = md_op_e'(op);
    // in_ready is purely IDLE; flush vetoes the accept itself
    assign w_accept = in_valid && (r_state == IDLE) && !flush;
    assign w_s1     = is_signed_rs1(w_op) && rs1_data[XLEN-1];
    assign w_s2     = is_signed_rs2(w_op) && rs2_data[XLEN-1];
    // Negating the most-negative value yields 2^(XLEN-1), the correct magnitude
    assign w_abs1   = w_s1 ? (~rs1_data + 1'b1) : rs1_data;
    assign w_abs2   = w_s2 ? (~rs2_data + 1'b1) : rs2_data;
    assign w_div0   = is_div(w_op) && (rs2_data == '0);
    assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (rs1_data == c_most_neg) && (rs2_data == '1);
    assign w_fast   = w_div0 || w_ovf;

    // Architecturally defined results for divide-by-zero and signed overflow
    always_comb begin
        w_fast_result = '0;
        if (w_div0) begin
            w_fast_result = w_op[1] ? rs1_data : '1;
        end else if (w_ovf) begin
            w_fast_result = w_op[1] ? '0 : rs1_data;
        end
    end

    // One shift-add step and one restoring-divide step per CALC cycle
    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                         (r_prod[0] ? {1'b0, r_abs_a} : {(XLEN+1){1'b0}});
    assign w_div_shift = {r_rem, r_quo[XLEN-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_abs_b};

    assign w_prod_fix = r_neg_res ? (~r_prod + 1'b1) : r_prod;
    assign w_quo_fix  = r_neg_res ? (~r_quo + 1'b1)  : r_quo;
    assign w_rem_fix  = r_neg_rem ? (~r_rem + 1'b1)  : r_rem;

    // Final result selection after sign correction
    always_comb begin
        w_fix_result = '0;
        unique case (r_op)
            OP_MUL:                        w_fix_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_result = w_quo_fix;
            OP_REM, OP_REMU:               w_fix_result = w_rem_fix;
            default:                       w_fix_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_accept) w_next_state = w_fast ? DONE : CALC;
                CALC:    if (r_cnt == CNT_W'(1)) w_next_state = FIXUP;
                FIXUP:   w_next_state = DONE;
                DONE:    if (out_ready) w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on accept, then iterate while in CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_abs_a   <= '0;
            r_abs_b   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_neg_res <= w_s1 ^ w_s2;
            r_neg_rem <= w_s1;
            r_abs_a   <= w_abs1;
            r_abs_b   <= w_abs2;
            r_prod    <= {{XLEN{1'b0}}, w_abs2};
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_cnt     <= CNT_W'(XLEN);
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (is_div(r_op)) begin
                if (!w_div_sub[XLEN]) begin
                    r_rem <= w_div_sub[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    r_rem <= w_div_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
            end
        end
    end

    // Result register: loaded by the fast path or by FIXUP, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_accept && w_fast) begin
            r_result <= w_fast_result;
        end else if ((r_state == FIXUP) && !flush) begin
            r_result <= w_fix_result;
        end
    end

    assign result = r_result;

endmodule : alu_muldiv
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Directed self-checking bench for alu_muldiv (XLEN=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int c_xlen     = 32;
    localparam int c_lat_norm = c_xlen + 2;
    localparam int c_lat_fast = 1;
    localparam int c_timeout  = 200;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [c_xlen-1:0] rs1_data;
    logic [c_xlen-1:0] rs2_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [c_xlen-1:0] result;
    logic              busy;

    int n_cmp;
    int n_err;

    alu_muldiv #(.XLEN(c_xlen)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op at a negedge, wait for out_valid, check result and latency
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check_eq("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < c_timeout) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_valid"},   {63'd0, out_valid}, 64'd1);
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_result"},  {32'd0, result}, {32'd0, exp});
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_idle_ready"}, {63'd0, in_ready},  64'd1);
        check_eq({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        start_op(o, a, b);
        wait_result(tag, exp, exp_lat);
        take_result(tag);
    endtask

    initial begin
        logic seen_valid;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        rs1_data  = '0;
        rs2_data  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("reset_busy",      {63'd0, busy},      64'd0);
        check_eq("reset_result",    {32'd0, result},    64'd0);
        rst = 1'b0;

        // Multiply family with both operands all ones
        run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, c_lat_norm);
        run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, c_lat_norm);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_lat_norm);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_lat_norm);
        run_op("mul_7x6",  3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, c_lat_norm);
        run_op("mulh_mix", 3'b001, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, c_lat_norm);

        // Divide family with -7 / 2
        run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, c_lat_norm);
        run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, c_lat_norm);
        run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, c_lat_norm);
        run_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, c_lat_norm);
        run_op("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, c_lat_norm);
        run_op("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, c_lat_norm);

        // Divide by zero and signed overflow take the one-cycle path
        run_op("div0_div",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, c_lat_fast);
        run_op("div0_rem",  3'b110, 32'd5, 32'd0, 32'd5,         c_lat_fast);
        run_op("div0_divu", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, c_lat_fast);
        run_op("div0_remu", 3'b111, 32'd5, 32'd0, 32'd5,         c_lat_fast);
        run_op("ovf_div", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, c_lat_fast);
        run_op("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, c_lat_fast);

        // Backpressure: result must hold while out_ready stays low
        start_op(3'b000, 32'd9, 32'd11);
        wait_result("bp", 32'd99, c_lat_norm);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold_result", {32'd0, result},    64'd99);
            check_eq("bp_hold_valid",  {63'd0, out_valid}, 64'd1);
            check_eq("bp_in_ready",    {63'd0, in_ready},  64'd0);
            check_eq("bp_busy",        {63'd0, busy},      64'd1);
        end
        take_result("bp");

        // flush in DONE beats out_ready and drops out_valid
        start_op(3'b000, 32'd2, 32'd3);
        wait_result("dflush", 32'd6, c_lat_norm);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check_eq("dflush_valid", {63'd0, out_valid}, 64'd0);
        check_eq("dflush_ready", {63'd0, in_ready},  64'd1);

        // flush during CALC cycle 5 abandons the operation
        start_op(3'b000, 32'd1000, 32'd1000);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("cflush_busy",  {63'd0, busy},     64'd0);
        check_eq("cflush_ready", {63'd0, in_ready}, 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check_eq("cflush_no_valid", {63'd0, seen_valid}, 64'd0);
        run_op("after_flush", 3'b000, 32'd3, 32'd4, 32'd12, c_lat_norm);

        // flush together with in_valid in IDLE must not accept
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 3'b000;
        rs1_data = 32'd5;
        rs2_data = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("iflush_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-CALC
        start_op(3'b000, 32'd5, 32'd7);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_busy",      {63'd0, busy},      64'd0);
        check_eq("arst_result",    {32'd0, result},    64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 3'b101, 32'd100, 32'd7, 32'd14, c_lat_norm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_muldiv
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit implementing the RV32M/RV64M operation set.
- Sits beside the single-cycle integer ALU in the execute stage. It is used for M-extension instructions, which the ALU does not support.
- Iterative, one bit per cycle, with valid/ready handshakes on both the operand side and the result side.
- The execute stage stalls while the unit is busy. It uses a flush to abandon an in-flight operation on redirect.

Parameters:
XLEN, 32, operand/result width; legal values 32 and 64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands and op are valid this cycle
in_ready  out  1  unit can accept an operation
op  in  3  operation, equal to instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  in  XLEN  operand 1 (dividend/multiplicand)
rs2_data  in  XLEN  operand 2 (divisor/multiplier)
flush  in  1  synchronous abort of any operation, highest priority after rst
out_valid  out  1  result valid
out_ready  in  1  consumer takes result this cycle
result  out  XLEN  operation result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal registers 0.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready. Latch op and operands; compute operand signs and absolute values per op.
    - MULH/DIV/REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - Others: unsigned.
  - IDLE -> DONE (fast path, out_valid 1 cycle after accept) in two cases:
    - Divide by zero (rs2==0, op[2]=1): DIV/DIVU=all ones; REM/REMU=rs1.
    - Signed overflow (DIV/REM, rs1=most-negative, rs2=all ones): DIV=rs1; REM=0.
  - IDLE -> CALC otherwise; counter=XLEN.
  - CALC: one iteration per cycle; counter decrements; at counter==1 -> FIXUP.
    - Multiply: shift-add on a 2*XLEN product register.
    - Divide: restoring, one quotient bit per cycle, XLEN-bit remainder plus 1 guard bit.
  - FIXUP: one cycle.
    - Apply sign negation: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
    - Select low half (MUL) or high half (MULH*), quotient or remainder.
    - Register into result. -> DONE.
  - DONE: out_valid=1; result held stable until out_valid&&out_ready, then -> IDLE (out_valid=0 next cycle).
- Latency:
  - Normal op: out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32).
  - Fast path: 1 cycle.
- Throughput: in_ready only in IDLE. There is no accept in the same cycle as result handoff, so the minimum spacing is latency+1.
- in_ready is a pure function of state and does not depend on in_valid.
- flush:
  - In any state, next state is IDLE, out_valid=0, and any pending result is discarded.
  - In DONE, flush wins over out_ready; the consumer must ignore that cycle's result.
  - flush with in_valid in IDLE: the operation is not accepted.
- rst mid-operation: immediate return to reset values; no partial result is ever presented.
- Widths: all internal arithmetic at XLEN+1 or 2*XLEN bits; no truncation before FIXUP.
- MULHSU: signed×unsigned 2*XLEN product, high half.
- No X propagation: result=0 in all states until the first FIXUP or fast path.

Decomposition:
- Shared package alu_muldiv_pkg holds:
  - typedef enum logic[2:0] md_op_e (values as op encoding above);
  - typedef enum logic[1:0] md_state_e {IDLE, CALC, FIXUP, DONE};
  - helper functions is_div(op), is_signed_rs1(op), is_signed_rs2(op).
- No sub-module; the multiply and divide datapaths share the counter and FSM in one module.
- The decoder extends the existing ALU control to route funct7=0000001 here.

Test Plan:
- MUL/MULH/MULHU/MULHSU with rs1=rs2=0xFFFFFFFF:
  - result 0x00000001 / 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF;
  - out_valid exactly 34 cycles after accept.
- DIV/REM/DIVU/REMU with rs1=0xFFFFFFF9 (-7), rs2=2:
  - result 0xFFFFFFFD / 0xFFFFFFFF / 0x7FFFFFFC / 0x00000001.
- Divide by zero, rs1=5, rs2=0:
  - DIV=0xFFFFFFFF, REM=5, DIVU=0xFFFFFFFF, REMU=5;
  - out_valid 1 cycle after accept.
- Overflow, rs1=0x80000000, rs2=0xFFFFFFFF:
  - DIV=0x80000000, REM=0; fast path latency 1.
- Backpressure: out_ready held 0 for 10 cycles in DONE:
  - result stable, in_ready=0, busy=1;
  - out_ready pulse -> IDLE next cycle with in_ready=1.
- Abort:
  - flush at CALC cycle 5 -> IDLE next cycle, out_valid never asserted; next op MUL 3×4 returns 12.
  - rst pulse mid-CALC -> all outputs at reset values asynchronously.
